// File: rtl/flag_event_ctrl.sv
// -----------------------------------------------------------------------------
// flag_event_ctrl
//   Destination-domain consumer of a synchronized flag. A flag high period that
//   lasts at least MIN_HIGH samples, and that began after a low sample taken
//   while enabled, becomes exactly one event. Events are queued in a saturating
//   pending counter. The queue is drained towards the SRAM-side controller over
//   a four-phase req/ack handshake. A request that sees no ack within
//   ACK_TIMEOUT cycles is abandoned.
//
// Ports
//   clk                  destination clock
//   rst_active_high      synchronous active-high reset
//   flag_in_active_high  synchronized flag
//   enable               1 = qualifier may arm; 0 = no new events
//   ack_in_active_high   acknowledge from SRAM controller
//   clr_sticky           1-cycle pulse clearing overflow/timeout stickies
//   req_out_active_high  request to SRAM controller
//   event_pulse          1-cycle strobe per qualified flag pulse
//   pending_cnt          events queued, not yet handshaken
//   busy                 handshake active or events pending
//   overflow_sticky      an event was dropped on a full queue
//   timeout_sticky       a request was abandoned on timeout
// -----------------------------------------------------------------------------
module flag_event_ctrl #(
  parameter int MIN_HIGH    = 2,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_active_high,
  input  logic             flag_in_active_high,
  input  logic             enable,
  input  logic             ack_in_active_high,
  input  logic             clr_sticky,
  output logic             req_out_active_high,
  output logic             event_pulse,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             busy,
  output logic             overflow_sticky,
  output logic             timeout_sticky
);

  localparam int HC_W = $clog2(MIN_HIGH + 1);
  localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(MIN_HIGH);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(MIN_HIGH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [HC_W-1:0]  hi_cnt_reg;
  logic             armed_reg;
  logic             event_pulse_reg;
  logic [CNT_W-1:0] pending_reg, pending_next;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             overflow_reg, timeout_reg;

  logic fire;
  logic dec;
  logic overflow_set;
  logic timeout_set;
  logic to_expired;

  // ---------------------------------------------------------------------------
  // Qualifier. hi_cnt_reg holds the number of consecutive high samples taken
  // before the current one, so the current sample is number hi_cnt_reg+1.
  // The count saturates at MIN_HIGH: once fired the qualifier is disarmed
  // and further counting is irrelevant until the next low sample.
  // ---------------------------------------------------------------------------
  assign fire = armed_reg && enable && flag_in_active_high && (hi_cnt_reg == HC_LAST);

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      hi_cnt_reg      <= '0;
      armed_reg       <= 1'b0;
      event_pulse_reg <= 1'b0;
    end else begin
      event_pulse_reg <= fire;

      if (!flag_in_active_high) begin
        hi_cnt_reg <= '0;
      end else if (hi_cnt_reg != HC_MAX) begin
        hi_cnt_reg <= hi_cnt_reg + HC_W'(1);
      end

      // Arming needs a low sample under enable, so a flag that is already high
      // at reset release or at enable rise is ignored until it drops.
      if (!enable) begin
        armed_reg <= 1'b0;
      end else if (!flag_in_active_high) begin
        armed_reg <= 1'b1;
      end else if (fire) begin
        armed_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  assign to_expired = (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      state_reg  <= IDLE;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      // Held at zero outside REQ, so every REQ entry starts from a clean count.
      if (state_reg == REQ) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    dec         = 1'b0;
    timeout_set = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // ack has priority over a timeout expiring in the same cycle.
        if (ack_in_active_high) begin
          dec        = 1'b1;
          state_next = WAIT_DROP;
        end else if (to_expired) begin
          dec         = 1'b1;
          timeout_set = 1'b1;
          state_next  = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!ack_in_active_high) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending counter: saturating, increment and decrement cancel out.
  // A decrement implies the FSM left IDLE on a nonzero count, so it can never
  // underflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending_reg;
    overflow_set = 1'b0;
    case ({fire, dec})
      2'b10: begin
        if (pending_reg == CNT_MAX) begin
          overflow_set = 1'b1;
        end else begin
          pending_next = pending_reg + CNT_W'(1);
        end
      end
      2'b01:   pending_next = pending_reg - CNT_W'(1);
      default: pending_next = pending_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      // A set condition coinciding with clr_sticky wins.
      overflow_reg <= overflow_set | (overflow_reg & ~clr_sticky);
      timeout_reg  <= timeout_set  | (timeout_reg  & ~clr_sticky);
    end
  end

  assign req_out_active_high = (state_reg == REQ);
  assign event_pulse         = event_pulse_reg;
  assign pending_cnt         = pending_reg;
  assign busy                = (state_reg != IDLE) || (pending_reg != '0);
  assign overflow_sticky     = overflow_reg;
  assign timeout_sticky      = timeout_reg;

endmodule

// File: tb/tb_flag_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_event_ctrl
//   Directed scenarios followed by randomized stimulus, all checked cycle by
//   cycle against a behavioural model of the flag qualifier, event queue and
//   request/ack handshake.
// -----------------------------------------------------------------------------
module tb_flag_event_ctrl;

  localparam int MIN_HIGH    = 2;
  localparam int CNT_W       = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int TO_W        = 8;
  localparam int MAXP        = (1 << CNT_W) - 1;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;

  logic             clk = 1'b0;
  logic             rst_active_high;
  logic             flag_in_active_high;
  logic             enable;
  logic             ack_in_active_high;
  logic             clr_sticky;
  logic             req_out_active_high;
  logic             event_pulse;
  logic [CNT_W-1:0] pending_cnt;
  logic             busy;
  logic             overflow_sticky;
  logic             timeout_sticky;

  always #5 clk = ~clk;

  flag_event_ctrl #(
    .MIN_HIGH   (MIN_HIGH),
    .CNT_W      (CNT_W),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TO_W       (TO_W)
  ) dut (
    .clk                (clk),
    .rst_active_high    (rst_active_high),
    .flag_in_active_high(flag_in_active_high),
    .enable             (enable),
    .ack_in_active_high (ack_in_active_high),
    .clr_sticky         (clr_sticky),
    .req_out_active_high(req_out_active_high),
    .event_pulse        (event_pulse),
    .pending_cnt        (pending_cnt),
    .busy               (busy),
    .overflow_sticky    (overflow_sticky),
    .timeout_sticky     (timeout_sticky)
  );

  int checks = 0;
  int errors = 0;
  int dut_ev = 0;
  int max_pend = 0;

  // Behavioural model state
  int m_run;      // consecutive high samples seen so far
  bit m_armed;    // a low sample under enable has been seen since last event
  int m_pend;
  int m_phase;
  int m_age;      // completed cycles in the current request
  bit m_ev, m_ovf, m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit f, input bit en, input bit a, input bit c, input bit r);
    bit fire, dec, tmo;
    if (r) begin
      m_run = 0; m_armed = 0; m_pend = 0; m_phase = PH_IDLE; m_age = 0;
      m_ev = 0; m_ovf = 0; m_to = 0;
      return;
    end
    fire = m_armed && en && f && (m_run + 1 == MIN_HIGH);
    tmo  = (m_phase == PH_REQ) && !a && (m_age + 1 == ACK_TIMEOUT);
    dec  = (m_phase == PH_REQ) && (a || tmo);

    if (c) begin
      m_ovf = 0;
      m_to  = 0;
    end
    if (tmo) m_to = 1;
    if (fire && !dec && m_pend == MAXP) m_ovf = 1;
    else m_pend = m_pend + int'(fire) - int'(dec);

    case (m_phase)
      PH_IDLE: if (m_pend - int'(fire) + int'(dec) != 0) begin m_phase = PH_REQ; m_age = 0; end
      PH_REQ:  if (dec) m_phase = PH_WAIT; else m_age++;
      default: if (!a) m_phase = PH_IDLE;
    endcase

    m_ev  = fire;
    m_run = f ? m_run + 1 : 0;
    if (!en) m_armed = 0;
    else if (!f) m_armed = 1;
    else if (fire) m_armed = 0;
  endtask

  task automatic cycle(input bit f, input bit en, input bit a, input bit c, input bit r);
    int old_pend;
    old_pend = m_pend;
    flag_in_active_high = f;
    enable              = en;
    ack_in_active_high  = a;
    clr_sticky          = c;
    rst_active_high     = r;
    @(posedge clk);
    // IDLE decides on the pending count held before this edge
    m_pend = old_pend;
    model_step(f, en, a, c, r);
    #1;
    if (event_pulse === 1'b1) dut_ev++;
    if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
    chk("event_pulse", event_pulse, m_ev);
    chk("req", req_out_active_high, m_phase == PH_REQ);
    chk("pending", pending_cnt, m_pend);
    chk("busy", busy, (m_phase != PH_IDLE) || (m_pend != 0));
    chk("overflow", overflow_sticky, m_ovf);
    chk("timeout", timeout_sticky, m_to);
  endtask

  task automatic do_reset();
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
  endtask

  initial begin
    int req_len;
    bit f, en, a, c, r;
    int mode;

    rst_active_high = 1; flag_in_active_high = 0; enable = 0;
    ack_in_active_high = 0; clr_sticky = 0;

    // 1: flag already high at reset release does not fire
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    chk("t1_rst_req", req_out_active_high, 0);
    chk("t1_rst_pend", pending_cnt, 0);
    dut_ev = 0;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
    chk("t1_no_event", dut_ev, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("t1_event", dut_ev, 1);

    // 2: short pulse ignored; long pulse gives one event on the second sample
    do_reset();
    dut_ev = 0;
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t2_short", dut_ev, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 0);
      chk("t2_latency", event_pulse, (i == 1));
      if (i == 1) chk("t2_pend", pending_cnt, 1);
    end
    chk("t2_count", dut_ev, 1);

    // 3: normal handshake
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 10 && req_out_active_high !== 1'b1; i++) cycle(0, 1, 0, 0, 0);
    chk("t3_req_up", req_out_active_high, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    chk("t3_req_fall", req_out_active_high, 0);
    chk("t3_pend0", pending_cnt, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t3_idle", busy, 0);

    // 4: timeout after ACK_TIMEOUT request cycles
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    req_len = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (req_out_active_high === 1'b1) req_len++;
    end
    chk("t4_req_len", req_len, ACK_TIMEOUT);
    chk("t4_tmo", timeout_sticky, 1);
    chk("t4_pend", pending_cnt, 0);
    cycle(0, 1, 0, 1, 0);
    chk("t4_clr", timeout_sticky, 0);

    // 5: saturation with ack held low
    do_reset();
    max_pend = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
    end
    chk("t5_ovf", overflow_sticky, 1);
    chk("t5_max", max_pend, MAXP);

    // 6: reset mid-request with three events queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
    end
    chk("t6_pend3", pending_cnt, 3);
    chk("t6_in_req", req_out_active_high, 1);
    cycle(0, 1, 0, 0, 1);
    chk("t6_req0", req_out_active_high, 0);
    chk("t6_pend0", pending_cnt, 0);
    chk("t6_busy0", busy, 0);

    // Randomized traffic
    do_reset();
    a = 0;
    for (int i = 0; i < 4000; i++) begin
      mode = (i / 250) % 3;
      f  = ($urandom_range(0, 2) != 0);
      en = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 19) == 0);
      r  = (mode == 0) && ($urandom_range(0, 149) == 0);
      case (mode)
        0: a = ($urandom_range(0, 3) == 0);
        1: a = 0;
        default: begin
          if (m_phase == PH_REQ && $urandom_range(0, 2) == 0) a = 1;
          else if (m_phase != PH_REQ && $urandom_range(0, 1) == 0) a = 0;
        end
      endcase
      cycle(f, en, a, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
